// File: rtl/mc6502_bus_pkg.sv
// Shared types and helpers for the MC6502 external bus front end.
package mc6502_bus_pkg;

    typedef enum logic {
        PH1 = 1'b0,
        PH2 = 1'b1
    } phase_e;

    localparam int WAIT_CNT_W = 4;

    function automatic logic in_wait_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mc6502_phase_gen.sv
// Two-phase bus clock generator: DIV clks of PH1, then DIV clks of PH2.
module mc6502_phase_gen
    import mc6502_bus_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic   clk,
    input  logic   rst_x,
    output phase_e o_state,
    output logic   o_phi1,
    output logic   o_phi2,
    output logic   o_first_ph1,
    output logic   o_last_ph2
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    phase_e        r_state;
    phase_e        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_phi1;
    logic          r_phi2;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state <= PH1;
            r_cnt   <= '0;
            r_phi1  <= 1'b1;
            r_phi2  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_phi1  <= (w_state_nx == PH1);
            r_phi2  <= (w_state_nx == PH2);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
            w_cnt_nx   = '0;
            w_state_nx = (r_state == PH1) ? PH2 : PH1;
        end
    end

    always_comb begin
        o_state     = r_state;
        o_phi1      = r_phi1;
        o_phi2      = r_phi2;
        o_first_ph1 = (r_state == PH1) && (r_cnt == '0);
        o_last_ph2  = (r_state == PH2) && (r_cnt == LAST);
    end

endmodule

// File: rtl/mc6502_bus_interface.sv
// MC6502 external bus front end: registered pins, RDY stretch, wait states.
module mc6502_bus_interface
    import mc6502_bus_pkg::*;
#(
    parameter int            AW           = 16,
    parameter int            DW           = 8,
    parameter int            DIV          = 2,
    parameter logic [AW-1:0] WAIT_BASE    = 'hC000,
    parameter logic [AW-1:0] WAIT_MASK    = 'hF000,
    parameter int            WAIT_N       = 0,
    parameter int            RDY_ON_WRITE = 0
) (
    input  logic          clk,
    input  logic          rst_x,
    input  logic          i_req,
    input  logic          i_we,
    input  logic          i_sync,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_ack,
    output logic [DW-1:0] o_rdata,
    output logic          o_phi1,
    output logic          o_phi2,
    output logic [AW-1:0] o_ab,
    output logic          o_rw,
    output logic          o_sync,
    output logic [DW-1:0] o_db,
    output logic          o_db_oe,
    input  logic [DW-1:0] i_db,
    input  logic          i_rdy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_N);

    phase_e                w_state;
    logic                  w_first;
    logic                  w_last;
    logic                  w_start;
    logic                  w_stall;
    logic                  r_busy;
    logic                  r_we;
    logic                  r_rw;
    logic                  r_sync;
    logic                  r_ack;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_wdata;
    logic [DW-1:0]         r_rdata;
    logic [WAIT_CNT_W-1:0] r_wait;

    mc6502_phase_gen #(
        .DIV (DIV)
    ) u_phase (
        .clk         (clk),
        .rst_x       (rst_x),
        .o_state     (w_state),
        .o_phi1      (o_phi1),
        .o_phi2      (o_phi2),
        .o_first_ph1 (w_first),
        .o_last_ph2  (w_last)
    );

    assign w_start = w_first && !r_busy;
    assign w_stall = (r_wait != '0) ||
                     (!i_rdy && (!r_we || (RDY_ON_WRITE != 0)));

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_rw    <= 1'b1;
            r_sync  <= 1'b0;
            r_ack   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wait  <= '0;
        end else begin
            r_ack <= 1'b0;
            if (w_start) begin
                r_busy <= i_req;
                r_sync <= i_req & i_sync;
                r_rw   <= !(i_req & i_we);
                if (i_req) begin
                    r_addr  <= i_addr;
                    r_we    <= i_we;
                    r_wdata <= i_wdata;
                    r_wait  <= in_wait_window(32'(i_addr), 32'(WAIT_BASE),
                                              32'(WAIT_MASK)) ? WAIT_LD : '0;
                end
            end
            // Repeats keep every pin latched; only the wait count moves.
            if (w_last && r_busy) begin
                if (w_stall) begin
                    if (r_wait != '0) r_wait <= r_wait - 1'b1;
                end else begin
                    r_ack  <= 1'b1;
                    r_busy <= 1'b0;
                    if (!r_we) r_rdata <= i_db;
                end
            end
        end
    end

    assign o_ack   = r_ack;
    assign o_rdata = r_rdata;
    assign o_ab    = r_addr;
    assign o_rw    = r_rw;
    assign o_sync  = r_sync;
    assign o_db    = r_wdata;
    assign o_db_oe = r_busy && r_we && (w_state == PH2);

endmodule

// File: doc/mc6502_bus_interface.md
Name: mc6502_bus_interface

Overview:
- Parametrised external-bus front end for the MC6502 core.
- Replaces the fixed pass-through (phi1 = clk, phi2 = !clk, combinational tri-state split) with four pieces of logic:
  - a divided two-phase bus clock;
  - a registered address/data/rw path;
  - RDY-driven cycle repetition;
  - programmable wait-state insertion for one address window.
- Sits between the core's memory controller (request/ack handshake) and the chip pins.

Parameters:
- AW, 16: address width.
- DW, 8: data width.
- DIV, 2: clk cycles per bus phase; must be >= 1.
- WAIT_BASE, 16'hC000: base of the slow address window.
- WAIT_MASK, 16'hF000: compare mask for the slow window.
- WAIT_N, 0: extra full bus cycles inserted for accesses inside the window; range 0..15.
- RDY_ON_WRITE, 0: 0 = RDY ignored on writes (NMOS behaviour); 1 = RDY stalls writes too (CMOS behaviour).

Ports:
- clk  in  1  system clock.
- rst_x  in  1  asynchronous active-low reset.
- i_req  in  1  core request; level signal, sampled only at bus-cycle start.
- i_we  in  1  1 = write, 0 = read.
- i_sync  in  1  request is an opcode fetch.
- i_addr  in  AW  request address.
- i_wdata  in  DW  write data.
- o_ack  out  1  one-clk pulse when the bus cycle completes.
- o_rdata  out  DW  read data; valid with o_ack and held until the next read ack.
- o_phi1  out  1  bus phase 1.
- o_phi2  out  1  bus phase 2.
- o_ab  out  AW  address bus.
- o_rw  out  1  1 = read, 0 = write.
- o_sync  out  1  opcode-fetch strobe.
- o_db  out  DW  write data to the pad.
- o_db_oe  out  1  data pad output enable.
- i_db  in  DW  data from the pad.
- i_rdy  in  1  ready; low stretches the cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_x low, including mid-cycle):
  - FSM in PH1, phase counter = 0, wait counter = 0.
  - Outputs: o_phi1 = 1, o_phi2 = 0, o_ab = 0, o_rw = 1, o_sync = 0, o_db = 0, o_db_oe = 0, o_ack = 0, o_rdata = 0.
  - No partial write completes and no ack is issued.
- Phase generator: free-running after reset. Sequence is PH1 for DIV clks, then PH2 for DIV clks, repeating.
  - o_phi1 = (state == PH1); o_phi2 = (state == PH2). Both are registered and never high together.
- Bus-cycle start (the first clk of PH1), with no cycle pending:
  - i_req = 1: latch i_addr, i_we, i_wdata, i_sync. Then drive o_ab = addr, o_rw = !we, o_sync = sync.
    - Load the wait counter with WAIT_N if (addr & WAIT_MASK) == WAIT_BASE, else 0.
  - i_req = 0: idle cycle. o_rw = 1, o_sync = 0, o_ab holds its last value, no ack.
- Inputs arriving mid-cycle are ignored; the latched values persist until completion.
- Write cycle: o_db = latched data for the whole cycle. o_db_oe = 1 only while in PH2 of a write cycle, deasserting on the clk PH2 ends.
- Completion check on the last clk of PH2:
  - stall = (wait counter != 0) OR (i_rdy == 0 AND (read OR RDY_ON_WRITE)).
  - stall = 1: the cycle repeats (new PH1/PH2 pair) with identical o_ab/o_rw/o_db. The wait counter decrements if non-zero. o_sync is held on repeats.
  - stall = 0: o_ack = 1 for exactly one clk. On reads, o_rdata <= i_db on the same edge. The next PH1 is a new cycle start.
- Latency, unstalled: ack is asserted 2*DIV clks after the accepting edge.
  - Each stall adds 2*DIV clks.
  - A window access with RDY high takes (WAIT_N+1)*2*DIV clks.
- Back-to-back requests: if i_req is high at the PH1 start immediately after an ack, the new request is accepted with no idle cycle. The core updates i_addr on the ack clk.
- Simultaneous wait counter > 0 and RDY low: the cycle repeats once per bus cycle. The counter keeps decrementing and completion needs both conditions clear.
- DIV = 1 degenerates to PH1/PH2 alternating every clk. The counter width is max(1, clog2(DIV)).

Decomposition:
- Package mc6502_bus_pkg:
  - state enum {PH1, PH2};
  - WAIT_CNT_W = 4;
  - helper function in_wait_window(addr, base, mask).
- Sub-module mc6502_phase_gen (DIV parameter): produces state, first_clk_of_ph1 and last_clk_of_ph2 strobes.
- The top of mc6502_bus_interface holds the latches, the stall/wait logic and the ack generation.

Test Plan:
1. Read, DIV=2, i_rdy=1: i_req with addr 0x1234 at PH1 start, i_db = 0xA5 -> o_ab = 0x1234, o_rw = 1, ack 4 clks after acceptance, o_rdata = 0xA5.
2. Read with i_rdy low for the first 2 bus cycles, DIV=2 -> ack delayed 8 clks (12 total); o_ab stable throughout; o_sync held when i_sync = 1.
3. Write 0x5A to 0x0200, i_rdy = 0:
   - RDY_ON_WRITE=0 -> completes in 4 clks; o_db_oe high only in PH2; o_db = 0x5A.
   - RDY_ON_WRITE=1 -> no ack until RDY rises.
4. WAIT_N=3, read of 0xC012 -> ack after 16 clks; read of 0x8012 -> ack after 4 clks; back-to-back requests run with no idle cycle between them.
5. rst_x pulsed low during PH2 of a write -> o_db_oe = 0 and o_phi1 = 1 immediately, no ack; after release the first cycle is PH1 with o_ab = 0.
6. i_req held low for 10 bus cycles -> phases toggle every DIV clks, o_rw = 1, o_sync = 0, o_ack never asserts.
